regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 32, register count (power of 2, 2..64); AW = clog2(NREGS).
REQ-003 Parameter NRP, default 2, read port count (1..4).
REQ-004 Parameter NWP, default 2, write port count (1..2).
REQ-005 Parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 One clock, clk; reset asynchronous, active-low, named rst_n.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst_n  input  1  async active-low reset.
REQ-009 we  input  NWP  per-port write enable.
REQ-010 waddr  input  NWP*AW  per-port write address, port i at bits [i*AW +: AW].
REQ-011 wdata  input  NWP*XLEN  per-port write data.
REQ-012 raddr  input  NRP*AW  per-port read address.
REQ-013 rdata  output  NRP*XLEN  per-port read data, combinational.
REQ-014 rbusy  output  NRP  per-port scoreboard busy flag of raddr, combinational.
REQ-015 rsv_en  input  1  reserve: mark rsv_addr busy (pending producer).
REQ-016 rsv_addr  input  AW  register to reserve.
REQ-017 flush  input  1  clear all busy flags (pipeline flush).

Function
REQ-018 Register 0 SHALL read 0, never be written, never be busy.
REQ-019 Writes SHALL commit on rising clk when we[i]=1 and waddr[i]!=0.
REQ-020 Two ports writing the same address same cycle: highest port index SHALL win.
REQ-021 BYPASS=0: rdata SHALL reflect array contents only; a write is visible the cycle after its edge.
REQ-022 BYPASS=1: if any we[i] targets raddr[j]!=0 this cycle, rdata[j] SHALL equal the winning wdata (REQ-020 priority), else array contents.
REQ-023 Scoreboard: one busy bit per register, bit 0 tied 0.
REQ-024 Busy bit SHALL set at the edge with rsv_en=1 (rsv_addr!=0); clear at the edge with a committing write to that address.
REQ-025 Reserve and write to same address same cycle: busy SHALL end set (new producer wins).
REQ-026 flush=1 SHALL clear every busy bit at the edge, overriding reserve and write; register data writes still commit.
REQ-027 rbusy[j] SHALL be the busy bit of raddr[j]; with BYPASS=1 it SHALL read 0 when a same-cycle write targets raddr[j].
REQ-028 rsv_en with rsv_addr=0 SHALL have no effect.
REQ-029 Read latency: 0 cycles (combinational); write latency: 1 edge.
REQ-030 No X SHALL propagate on rdata/rbusy for any in-range address after reset.

Reset
REQ-031 rst_n low SHALL asynchronously clear all registers to 0 and all busy bits to 0, including mid-write/reserve.
REQ-032 While rst_n low, rdata SHALL be 0 on all ports and rbusy 0; writes and reserves ignored.
REQ-033 First write SHALL commit at the first rising clk with rst_n high.

Verification
REQ-034 Reset, then read all addresses on every port -> rdata 0, rbusy 0.
REQ-035 we=2'b11, waddr0=waddr1=5, wdata0=0xAAAA_0000, wdata1=0x5555_1111; next cycle raddr0=5 -> 0x5555_1111.
REQ-036 BYPASS=1: we0=1 waddr0=7 wdata0=0x1234_5678, raddr1=7 same cycle -> rdata1=0x1234_5678, rbusy1=0; BYPASS=0 -> old value 0.
REQ-037 rsv_en addr 9; next cycle raddr0=9 -> rbusy0=1; write 9 -> next cycle rbusy0=0; reserve+write 9 same cycle -> rbusy0 stays 1.
REQ-038 Write x0 with 0xFFFF_FFFF and rsv_en addr 0 -> raddr=0 gives 0, rbusy 0.
REQ-039 Reserve 3 and 4, flush with write 3=0x77 same cycle -> rbusy 0 for both, reg3=0x77; assert rst_n low mid-sequence -> all 0 immediately.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a per-register busy scoreboard.
//
// Purpose
//   XLEN x NREGS register array with NWP write ports and NRP combinational read
//   ports. Register 0 is hard-wired to zero. Each register also has a busy
//   bit: a reservation marks it as waiting on a producer, and the producer's
//   write clears it. A flush clears every busy bit.
//
// Ports
//   clk       in   1          rising-edge clock for all state
//   rst_n     in   1          asynchronous active-low reset
//   we        in   NWP        per-port write enable
//   waddr     in   NWP*AW     per-port write address, port i at [i*AW +: AW]
//   wdata     in   NWP*XLEN   per-port write data,    port i at [i*XLEN +: XLEN]
//   raddr     in   NRP*AW     per-port read address
//   rdata     out  NRP*XLEN   per-port read data (combinational)
//   rbusy     out  NRP        per-port busy flag of raddr (combinational)
//   rsv_en    in   1          reserve rsv_addr (mark busy)
//   rsv_addr  in   AW         register to reserve
//   flush     in   1          clear all busy flags
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRP    = 2,
  parameter int NWP    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWP-1:0]      we,
  input  logic [NWP*AW-1:0]   waddr,
  input  logic [NWP*XLEN-1:0] wdata,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]      rbusy,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                flush
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Per-register resolved write for this cycle. Ports are scanned in
  // ascending order so the highest-indexed port targeting a register wins.
  logic [NREGS-1:0] wr_hit;
  logic [XLEN-1:0]  wr_val [NREGS];

  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NREGS; r++) begin
      wr_val[r] = '0;
    end
    for (int i = 0; i < NWP; i++) begin
      if (we[i] && (waddr[i*AW +: AW] != '0)) begin
        wr_hit[waddr[i*AW +: AW]] = 1'b1;
        wr_val[waddr[i*AW +: AW]] = wdata[i*XLEN +: XLEN];
      end
    end
  end

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_val[r];
        end
      end
    end
  end

  // Scoreboard update order matters: a committing write clears its bit,
  // then a reservation sets its bit (a new producer outranks the old one's
  // completion), and a flush overrides both.
  always_comb begin
    busy_nxt = busy & ~wr_hit;
    if (rsv_en && (rsv_addr != '0)) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  for (genvar j = 0; j < NRP; j++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_val;
    logic            use_fwd;
    logic [XLEN-1:0] arr_val;

    assign ra = raddr[j*AW +: AW];

    always_comb begin
      fwd_hit = 1'b0;
      fwd_val = '0;
      for (int i = 0; i < NWP; i++) begin
        if (we[i] && (waddr[i*AW +: AW] == ra)) begin
          fwd_hit = 1'b1;
          fwd_val = wdata[i*XLEN +: XLEN];
        end
      end
    end

    // Forwarding is suppressed during reset so that in-flight write data
    // cannot leak onto rdata while the array is held clear.
    assign use_fwd = (BYPASS != 0) && fwd_hit && (ra != '0) && rst_n;
    assign arr_val = (ra == '0) ? '0 : regs[ra];

    assign rdata[j*XLEN +: XLEN] = !rst_n ? '0 : (use_fwd ? fwd_val : arr_val);
    assign rbusy[j]              = rst_n && busy[ra] && !use_fwd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRP = 2;
  localparam int NWP = 2;
  localparam int AW = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NWP-1:0]      we = '0;
  logic [NWP*AW-1:0]   waddr = '0;
  logic [NWP*XLEN-1:0] wdata = '0;
  logic [NRP*AW-1:0]   raddr = '0;
  logic                rsv_en = 1'b0;
  logic [AW-1:0]       rsv_addr = '0;
  logic                flush = 1'b0;

  logic [NRP*XLEN-1:0] rdata_b, rdata_n;
  logic [NRP-1:0]      rbusy_b, rbusy_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP), .BYPASS(1)) u_dut_byp (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush));

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP), .BYPASS(0)) u_dut_nobyp (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush));

  // Behavioural model: register contents and busy flags.
  bit [31:0] m_regs [NREGS];
  bit [NREGS-1:0] m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) m_regs[r] = 0;
      m_busy = '0;
    end else begin
      for (int i = 0; i < NWP; i++) begin
        if (we[i] && waddr[i*AW +: AW] != 0) begin
          m_regs[waddr[i*AW +: AW]] = wdata[i*XLEN +: XLEN];
          m_busy[waddr[i*AW +: AW]] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      if (flush) m_busy = '0;
    end
  end

  function automatic bit same_cycle_write(int a);
    for (int i = 0; i < NWP; i++)
      if (we[i] && waddr[i*AW +: AW] == a[AW-1:0]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_rd(int j, bit byp);
    int a;
    a = int'(raddr[j*AW +: AW]);
    if (!rst_n || a == 0) return 32'h0;
    if (byp) begin
      for (int i = NWP-1; i >= 0; i--)
        if (we[i] && waddr[i*AW +: AW] == a[AW-1:0]) return wdata[i*XLEN +: XLEN];
    end
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_bz(int j, bit byp);
    int a;
    a = int'(raddr[j*AW +: AW]);
    if (!rst_n || a == 0) return 32'h0;
    if (byp && same_cycle_write(a)) return 32'h0;
    return {31'h0, m_busy[a]};
  endfunction

  // Hand-computed literal expectations, per read port.
  bit        chk_en = 1'b0;
  bit [1:0]  lit_mask = '0;
  logic [31:0] lit_d1 [NRP];
  logic [31:0] lit_d0 [NRP];
  bit          lit_b1 [NRP];
  bit          lit_b0 [NRP];

  task automatic check(string nm, int j, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s port%0d t=%0t: got %h expected %h", nm, j, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < NRP; j++) begin
        check("rdata_byp",   j, rdata_b[j*XLEN +: XLEN], exp_rd(j, 1'b1));
        check("rbusy_byp",   j, {31'h0, rbusy_b[j]},     exp_bz(j, 1'b1));
        check("rdata_nobyp", j, rdata_n[j*XLEN +: XLEN], exp_rd(j, 1'b0));
        check("rbusy_nobyp", j, {31'h0, rbusy_n[j]},     exp_bz(j, 1'b0));
        if (lit_mask[j]) begin
          check("lit_rdata_byp",   j, rdata_b[j*XLEN +: XLEN], lit_d1[j]);
          check("lit_rbusy_byp",   j, {31'h0, rbusy_b[j]},     {31'h0, lit_b1[j]});
          check("lit_rdata_nobyp", j, rdata_n[j*XLEN +: XLEN], lit_d0[j]);
          check("lit_rbusy_nobyp", j, {31'h0, rbusy_n[j]},     {31'h0, lit_b0[j]});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    lit_mask = '0;
    we = '0;
    rsv_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic set_w(int i, int a, logic [31:0] d);
    we[i] = 1'b1;
    waddr[i*AW +: AW] = a[AW-1:0];
    wdata[i*XLEN +: XLEN] = d;
  endtask

  task automatic set_r(int j, int a);
    raddr[j*AW +: AW] = a[AW-1:0];
  endtask

  task automatic set_lit(int j, logic [31:0] d1, bit b1, logic [31:0] d0, bit b0);
    lit_mask[j] = 1'b1;
    lit_d1[j] = d1;
    lit_b1[j] = b1;
    lit_d0[j] = d0;
    lit_b0[j] = b0;
  endtask

  initial begin
    chk_en = 1'b1;
    step();
    step();
    rst_n = 1'b1;

    // Read every address on every port after reset.
    for (int a = 0; a < NREGS; a++) begin
      step();
      set_r(0, a);
      set_r(1, a);
      set_lit(0, 0, 0, 0, 0);
      set_lit(1, 0, 0, 0, 0);
    end

    // Both ports write 5: port 1 wins, also on the forwarding path.
    step();
    set_w(0, 5, 32'hAAAA_0000);
    set_w(1, 5, 32'h5555_1111);
    set_r(0, 5);
    set_r(1, 0);
    set_lit(0, 32'h5555_1111, 0, 32'h0, 0);
    step();
    set_r(0, 5);
    set_lit(0, 32'h5555_1111, 0, 32'h5555_1111, 0);

    // Same-cycle forwarding vs. array-only read.
    step();
    set_w(0, 7, 32'h1234_5678);
    set_r(1, 7);
    set_lit(1, 32'h1234_5678, 0, 32'h0, 0);
    step();
    set_r(1, 7);
    set_lit(1, 32'h1234_5678, 0, 32'h1234_5678, 0);

    // Scoreboard on register 9.
    step();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    set_r(0, 9);
    set_lit(0, 0, 0, 0, 0);
    step();
    set_r(0, 9);
    set_lit(0, 0, 1, 0, 1);
    step();
    set_w(0, 9, 32'hCAFE_0009);
    set_lit(0, 32'hCAFE_0009, 0, 32'h0, 1);
    step();
    set_lit(0, 32'hCAFE_0009, 0, 32'hCAFE_0009, 0);
    step();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    set_w(0, 9, 32'hBEEF_0009);
    set_lit(0, 32'hBEEF_0009, 0, 32'hCAFE_0009, 0);
    step();
    set_lit(0, 32'hBEEF_0009, 1, 32'hBEEF_0009, 1);

    // Register 0: write and reserve have no effect.
    step();
    set_w(0, 0, 32'hFFFF_FFFF);
    rsv_en = 1'b1; rsv_addr = 5'd0;
    set_r(0, 0);
    set_r(1, 0);
    set_lit(0, 0, 0, 0, 0);
    set_lit(1, 0, 0, 0, 0);
    step();
    set_lit(0, 0, 0, 0, 0);
    set_lit(1, 0, 0, 0, 0);

    // Reserve 3 and 4, then flush together with a write to 3.
    step();
    rsv_en = 1'b1; rsv_addr = 5'd3;
    step();
    rsv_en = 1'b1; rsv_addr = 5'd4;
    step();
    flush = 1'b1;
    set_w(0, 3, 32'h77);
    set_r(0, 3);
    set_r(1, 4);
    set_lit(0, 32'h77, 0, 32'h0, 1);
    set_lit(1, 32'h0, 1, 32'h0, 1);
    step();
    set_lit(0, 32'h77, 0, 32'h77, 0);
    set_lit(1, 32'h0, 0, 32'h0, 0);

    // Asynchronous reset in the middle of a write and a reserve.
    step();
    set_w(0, 6, 32'h0000_0666);
    rsv_en = 1'b1; rsv_addr = 5'd5;
    set_r(0, 3);
    set_r(1, 9);
    #1;
    rst_n = 1'b0;
    set_lit(0, 0, 0, 0, 0);
    set_lit(1, 0, 0, 0, 0);
    step();
    set_w(0, 3, 32'h0000_0999);
    set_lit(0, 0, 0, 0, 0);
    // First write after release commits at the next edge.
    step();
    rst_n = 1'b1;
    set_w(0, 3, 32'h0000_0033);
    set_r(1, 9);
    set_lit(1, 0, 0, 0, 0);
    step();
    set_r(0, 3);
    set_lit(0, 32'h33, 0, 32'h33, 0);

    // Randomized traffic, biased to a few low registers for collisions.
    for (int n = 0; n < 1500; n++) begin
      step();
      if (n == 700) rst_n = 1'b0;
      if (n == 703) rst_n = 1'b1;
      for (int i = 0; i < NWP; i++) begin
        we[i] = ($urandom_range(0, 2) != 0);
        waddr[i*AW +: AW] = 5'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 31 : 7));
        wdata[i*XLEN +: XLEN] = $urandom;
      end
      for (int j = 0; j < NRP; j++)
        raddr[j*AW +: AW] = 5'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 31 : 7));
      rsv_en = ($urandom_range(0, 1) != 0);
      rsv_addr = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 15) == 0);
    end

    step();
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
